// File: rtl/ui_pkg.sv
// Shared types and constants for the UI pixel sink: framebuffer geometry,
// the buffered pixel payload and the sink FSM states.
package ui_pkg;

   localparam int unsigned FB_WIDTH_DEF  = 160;
   localparam int unsigned FB_HEIGHT_DEF = 120;
   localparam int unsigned ADDR_W        = 15;
   localparam int unsigned X_W           = 8;
   localparam int unsigned Y_W           = 7;
   localparam int unsigned COLOR_W       = 3;

   typedef struct packed {
      logic [X_W-1:0]     x;
      logic [Y_W-1:0]     y;
      logic [COLOR_W-1:0] color;
   } pixel_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_STREAM,
      ST_STALL
   } state_t;

   // Linear framebuffer address; wraps modulo 2^ADDR_W.
   function automatic logic [ADDR_W-1:0] pixel_addr(input logic [X_W-1:0] x,
                                                    input logic [Y_W-1:0] y,
                                                    input int unsigned    pitch);
      return ADDR_W'(y) * ADDR_W'(pitch) + ADDR_W'(x);
   endfunction

endpackage

// File: rtl/ui_pixel_sink_if.sv
// Plot request channel from the drawing unit plus the framebuffer write port.
interface ui_pixel_sink_if;
   import ui_pkg::*;

   logic                writeEn;
   logic [X_W-1:0]      x;
   logic [Y_W-1:0]      y;
   logic [COLOR_W-1:0]  color;
   logic                ready;
   logic                mem_busy;
   logic                mem_we;
   logic [ADDR_W-1:0]   mem_addr;
   logic [COLOR_W-1:0]  mem_data;

   modport master (
      output writeEn, x, y, color, mem_busy,
      input  ready, mem_we, mem_addr, mem_data
   );

   modport slave (
      input  writeEn, x, y, color, mem_busy,
      output ready, mem_we, mem_addr, mem_data
   );

endinterface

// File: rtl/ui_pixel_fifo.sv
// Synchronous pixel FIFO; pointers carry one extra wrap bit so full and
// empty are distinguishable without a separate counter.
module ui_pixel_fifo
   import ui_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_flush,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  pixel_t                   i_data,
   output pixel_t                   o_data,
   output logic                     o_empty,
   output logic                     o_full,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int unsigned AW = $clog2(DEPTH);

   pixel_t        r_mem [DEPTH];
   logic [AW:0]   r_wr_ptr;
   logic [AW:0]   r_rd_ptr;

   always_ff @(posedge clk) begin
      if (reset || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         if (i_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
   end

   // Storage needs no reset; only the pointers define valid contents.
   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
   end

   assign o_data  = r_mem[r_rd_ptr[AW-1:0]];
   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign o_count = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/ui_pixel_sink.sv
// Buffers plot requests and streams them into the framebuffer port.
// Optional UI_PIXEL_SINK_BOUNDS_CHECK_EN discards off-screen requests.
module ui_pixel_sink
   import ui_pkg::*;
#(
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned FB_WIDTH  = FB_WIDTH_DEF,
   parameter int unsigned FB_HEIGHT = FB_HEIGHT_DEF
) (
   input  logic              clk,
   input  logic              reset,
   ui_pixel_sink_if.slave    bus,
   input  logic              flush,
   output logic              idle,
   output logic              overflow,
   output logic [ADDR_W-1:0] pix_count
);

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   // Elaboration guards on the configuration.
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("ui_pixel_sink: DEPTH must be a power of two, at least 2");
   end
   if (FB_WIDTH * FB_HEIGHT > (32'd1 << ADDR_W)) begin : g_bad_geometry
      $error("ui_pixel_sink: framebuffer does not fit the address width");
   end

   state_t              r_state;
   logic                r_mem_we;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [COLOR_W-1:0]  r_mem_data;
   logic                r_overflow;
   logic [ADDR_W-1:0]   r_pix_count;

   pixel_t              w_in_pix;
   pixel_t              w_head;
   logic                w_empty;
   logic                w_full;
   logic [CNT_W-1:0]    w_count;
   logic                w_in_bounds;
   logic                w_push;
   logic                w_pop;
   logic                w_drop;
   logic                w_last_pop;

   assign w_in_pix = '{x: bus.x, y: bus.y, color: bus.color};

`ifdef UI_PIXEL_SINK_BOUNDS_CHECK_EN
   assign w_in_bounds = (32'(bus.x) < FB_WIDTH) && (32'(bus.y) < FB_HEIGHT);
`else
   assign w_in_bounds = 1'b1;
`endif

   // A pop never frees room for a push in the same cycle: push keys off full.
   assign w_push     = bus.writeEn && w_in_bounds && !w_full && !flush;
   assign w_drop     = bus.writeEn && w_in_bounds &&  w_full && !flush;
   assign w_pop      = !w_empty && !bus.mem_busy && !flush;
   assign w_last_pop = w_pop && !w_push && (w_count == CNT_W'(1));

   ui_pixel_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_flush (flush),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (w_in_pix),
      .o_data  (w_head),
      .o_empty (w_empty),
      .o_full  (w_full),
      .o_count (w_count)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_data  <= '0;
         r_overflow  <= 1'b0;
         r_pix_count <= '0;
      end else begin
         r_mem_we <= w_pop;
         if (w_pop) begin
            r_mem_addr <= pixel_addr(w_head.x, w_head.y, FB_WIDTH);
            r_mem_data <= w_head.color;
            if (r_pix_count != '1) r_pix_count <= r_pix_count + ADDR_W'(1);
         end
         if (w_drop) r_overflow <= 1'b1;

         if (flush) begin
            r_state <= ST_IDLE;
         end else begin
            case (r_state)
               ST_IDLE:   if (w_push) r_state <= ST_STREAM;
               ST_STREAM: begin
                  if (w_last_pop)        r_state <= ST_IDLE;
                  else if (bus.mem_busy) r_state <= ST_STALL;
               end
               // Leaving a stall pops the head, which may be the last entry.
               ST_STALL:  if (!bus.mem_busy) r_state <= w_last_pop ? ST_IDLE : ST_STREAM;
               default:   r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign bus.ready    = !w_full;
   assign bus.mem_we   = r_mem_we;
   assign bus.mem_addr = r_mem_addr;
   assign bus.mem_data = r_mem_data;
   assign idle         = (r_state == ST_IDLE) && !r_mem_we;
   assign overflow     = r_overflow;
   assign pix_count    = r_pix_count;

endmodule
